lookup_table_reload_ctrl: RTL and testbench

//  Sequences run-time reloads of the lookup_table RAM. Sits between the upstream symbol stream,
//  the table's lookup port and a coefficient source stream. On request it optionally waits for a

---
 rtl/lookup_table_reload_ctrl_if.sv | 52 +++++
 rtl/lookup_table_reload_ctrl.sv | 115 +++++++++++
 tb/tb_lookup_table_reload_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lookup_table_reload_ctrl_if.sv
// rtl/lookup_table_reload_ctrl_if.sv - stream and control bundle for the lookup table reload sequencer
interface lookup_table_reload_ctrl_if #(
  parameter int TDATA_WIDTH   = 32,
  parameter int ADDRESS_WIDTH = 8
);
  logic [ADDRESS_WIDTH-1:0] sym_in_tdata;
  logic                     sym_in_tvalid;
  logic                     sym_in_tlast;
  logic                     sym_in_tready;
  logic [ADDRESS_WIDTH-1:0] lut_in_tdata;
  logic                     lut_in_tvalid;
  logic                     lut_in_tlast;
  logic                     lut_in_tready;
  logic                     lut_out_tvalid;
  logic                     lut_out_tready;
  logic [TDATA_WIDTH-1:0]   cfg_in_tdata;
  logic                     cfg_in_tvalid;
  logic                     cfg_in_tlast;
  logic                     cfg_in_tready;
  logic [TDATA_WIDTH-1:0]   lut_load_tdata;
  logic                     lut_load_tvalid;
  logic                     lut_load_tlast;
  logic                     lut_load_tready;
  logic                     reload_req;
  logic                     reload_busy;
  logic                     reload_done;
  logic                     load_error;

  modport slave (
    input  sym_in_tdata, sym_in_tvalid, sym_in_tlast,
    output sym_in_tready,
    output lut_in_tdata, lut_in_tvalid, lut_in_tlast,
    input  lut_in_tready, lut_out_tvalid, lut_out_tready,
    input  cfg_in_tdata, cfg_in_tvalid, cfg_in_tlast,
    output cfg_in_tready,
    output lut_load_tdata, lut_load_tvalid, lut_load_tlast,
    input  lut_load_tready, reload_req,
    output reload_busy, reload_done, load_error
  );

  modport master (
    output sym_in_tdata, sym_in_tvalid, sym_in_tlast,
    input  sym_in_tready,
    input  lut_in_tdata, lut_in_tvalid, lut_in_tlast,
    output lut_in_tready, lut_out_tvalid, lut_out_tready,
    output cfg_in_tdata, cfg_in_tvalid, cfg_in_tlast,
    input  cfg_in_tready,
    input  lut_load_tdata, lut_load_tvalid, lut_load_tlast,
    output lut_load_tready, reload_req,
    input  reload_busy, reload_done, load_error
  );
endinterface

// File: rtl/lookup_table_reload_ctrl.sv
// rtl/lookup_table_reload_ctrl.sv - sequences run-time reloads of the lookup table RAM
module lookup_table_reload_ctrl #(
  parameter int TDATA_WIDTH   = 32,
  parameter int ADDRESS_WIDTH = 8,
  parameter int TABLE_DEPTH   = 256,
  parameter int FRAME_ALIGN   = 1
) (
  input logic                     aclk,
  input logic                     aresetn,
  lookup_table_reload_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_RUN        = 3'd0,
    S_WAIT_FRAME = 3'd1,
    S_DRAIN      = 3'd2,
    S_LOAD       = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_WORD = ADDRESS_WIDTH'(TABLE_DEPTH - 1);

  state_t                   r_state;
  state_t                   w_next;
  logic [1:0]               r_outstanding;
  logic [ADDRESS_WIDTH-1:0] r_word_cnt;
  logic                     r_load_error;

  logic                     w_pass;
  logic                     w_lut_in_fire;
  logic                     w_lut_out_fire;
  logic                     w_load_fire;
  logic                     w_last_word;
  logic                     w_load_tlast;
  logic [TDATA_WIDTH-1:0]   w_load_data;

  // Pass-through is gated by aresetn so every tvalid reads 0 while reset is held.
  assign w_pass         = aresetn && (r_state == S_RUN || r_state == S_WAIT_FRAME);
  assign w_lut_in_fire  = w_pass && bus.sym_in_tvalid && bus.lut_in_tready;
  assign w_lut_out_fire = bus.lut_out_tvalid && bus.lut_out_tready;
  assign w_load_fire    = (r_state == S_LOAD) && bus.cfg_in_tvalid && bus.lut_load_tready;
  assign w_last_word    = (r_word_cnt == LAST_WORD);
  assign w_load_tlast   = w_last_word || bus.cfg_in_tlast;
  assign w_load_data    = bus.cfg_in_tdata;

  always_comb begin
    w_next              = r_state;
    bus.lut_in_tdata    = bus.sym_in_tdata;
    bus.lut_in_tvalid   = 1'b0;
    bus.lut_in_tlast    = 1'b0;
    bus.sym_in_tready   = 1'b0;
    bus.lut_load_tdata  = w_load_data;
    bus.lut_load_tvalid = 1'b0;
    bus.lut_load_tlast  = 1'b0;
    bus.cfg_in_tready   = 1'b0;

    if (w_pass) begin
      bus.lut_in_tvalid = bus.sym_in_tvalid;
      bus.lut_in_tlast  = bus.sym_in_tlast;
      bus.sym_in_tready = bus.lut_in_tready;
    end

    if (r_state == S_LOAD) begin
      bus.lut_load_tvalid = bus.cfg_in_tvalid;
      bus.lut_load_tlast  = w_load_tlast;
      bus.cfg_in_tready   = bus.lut_load_tready;
    end

    case (r_state)
      S_RUN: begin
        if (bus.reload_req) w_next = (FRAME_ALIGN != 0) ? S_WAIT_FRAME : S_DRAIN;
      end
      S_WAIT_FRAME: begin
        if (w_lut_in_fire && bus.sym_in_tlast) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_outstanding == 2'd0) w_next = S_LOAD;
      end
      S_LOAD: begin
        if (w_load_fire && w_load_tlast) w_next = S_DONE;
      end
      S_DONE:  w_next = S_RUN;
      default: w_next = S_RUN;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= S_RUN;
      r_outstanding <= 2'd0;
      r_word_cnt    <= '0;
      r_load_error  <= 1'b0;
    end else begin
      r_state <= w_next;

      case ({w_lut_in_fire, w_lut_out_fire})
        2'b10:   r_outstanding <= r_outstanding + 2'd1;
        2'b01:   r_outstanding <= r_outstanding - 2'd1;
        default: r_outstanding <= r_outstanding;
      endcase

      if (r_state == S_DONE) r_word_cnt <= '0;
      else if (w_load_fire)  r_word_cnt <= r_word_cnt + 1'b1;

      // Source tlast must coincide exactly with the final table word.
      if (r_state == S_RUN && bus.reload_req) r_load_error <= 1'b0;
      else if (w_load_fire && (bus.cfg_in_tlast != w_last_word)) r_load_error <= 1'b1;
    end
  end

  assign bus.reload_busy = (r_state != S_RUN);
  assign bus.reload_done = (r_state == S_DONE);
  assign bus.load_error  = r_load_error;

endmodule

// File: tb/tb_lookup_table_reload_ctrl.sv
// tb/tb_lookup_table_reload_ctrl.sv - scoreboard bench for the lookup table reload sequencer
module tb_lookup_table_reload_ctrl;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int DEPTH = 256;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic [AW:0]   in_q[$];
  logic [DW:0]   load_q[$];
  logic          out_rdy = 1'b1;
  logic [1:0]    tb_cnt;

  lookup_table_reload_ctrl_if #(.TDATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  lookup_table_reload_ctrl #(
    .TDATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .TABLE_DEPTH(DEPTH), .FRAME_ALIGN(1)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .bus(bus)
  );

  always #5 aclk = ~aclk;

  // Behavioural lookup table: each accepted lookup produces one result later.
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) tb_cnt <= 2'd0;
    else tb_cnt <= tb_cnt + 2'((bus.lut_in_tvalid && bus.lut_in_tready) ? 1 : 0)
                          - 2'((bus.lut_out_tvalid && out_rdy) ? 1 : 0);
  end
  assign bus.lut_out_tvalid = (tb_cnt != 2'd0);
  assign bus.lut_out_tready = out_rdy;

  always @(negedge aclk) begin
    logic [AW:0] ei;
    logic [DW:0] el;
    if (aresetn) begin
      if (bus.lut_in_tvalid && bus.lut_in_tready) begin
        n_tests++;
        if (in_q.size() == 0) begin
          n_fail++;
          $display("FAIL lut_in_unexpected got %h required none", {bus.lut_in_tlast, bus.lut_in_tdata});
        end else begin
          ei = in_q.pop_front();
          if ({bus.lut_in_tlast, bus.lut_in_tdata} !== ei) begin
            n_fail++;
            $display("FAIL lut_in_beat got %h required %h", {bus.lut_in_tlast, bus.lut_in_tdata}, ei);
          end
        end
      end
      if (bus.lut_load_tvalid && bus.lut_load_tready) begin
        n_tests++;
        if (load_q.size() == 0) begin
          n_fail++;
          $display("FAIL lut_load_unexpected got %h required none", {bus.lut_load_tlast, bus.lut_load_tdata});
        end else begin
          el = load_q.pop_front();
          if ({bus.lut_load_tlast, bus.lut_load_tdata} !== el) begin
            n_fail++;
            $display("FAIL lut_load_beat got %h required %h", {bus.lut_load_tlast, bus.lut_load_tdata}, el);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_load(input string name);
    int k;
    k = 0;
    while (bus.cfg_in_tready !== 1'b1 && k < 20) begin
      cyc();
      k++;
    end
    n_tests++;
    if (bus.cfg_in_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_load_timeout got %0d cycles required load entry", name, k);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    bus.sym_in_tvalid = 1'b1; bus.sym_in_tdata = 8'h55; bus.sym_in_tlast = 1'b1;
    bus.cfg_in_tvalid = 1'b1; bus.cfg_in_tdata = '0;    bus.cfg_in_tlast = 1'b1;
    bus.lut_in_tready = 1'b1; bus.lut_load_tready = 1'b1; bus.reload_req = 1'b0;
    cyc(); cyc();
    @(negedge aclk);
    n_tests++;
    if ({bus.lut_in_tvalid, bus.lut_in_tlast, bus.sym_in_tready, bus.lut_load_tvalid, bus.lut_load_tlast,
         bus.cfg_in_tready, bus.reload_busy, bus.reload_done, bus.load_error} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b required 000000000",
               {bus.lut_in_tvalid, bus.lut_in_tlast, bus.sym_in_tready, bus.lut_load_tvalid, bus.lut_load_tlast,
                bus.cfg_in_tready, bus.reload_busy, bus.reload_done, bus.load_error});
    end
    bus.sym_in_tvalid = 1'b0; bus.sym_in_tlast = 1'b0;
    bus.cfg_in_tvalid = 1'b0; bus.cfg_in_tlast = 1'b0;
    cyc();
    aresetn = 1'b1;
    cyc();
  endtask

  task automatic test_passthrough();
    bus.lut_in_tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.sym_in_tdata = 8'(i); bus.sym_in_tlast = (i == 9); bus.sym_in_tvalid = 1'b1;
      in_q.push_back({(i == 9), 8'(i)});
      @(negedge aclk);
      n_tests++;
      if ({bus.reload_busy, bus.lut_in_tvalid, bus.lut_in_tlast, bus.lut_in_tdata} !== {1'b0, 1'b1, (i == 9), 8'(i)}) begin
        n_fail++;
        $display("FAIL passthrough_mirror got %h required %h",
                 {bus.reload_busy, bus.lut_in_tvalid, bus.lut_in_tlast, bus.lut_in_tdata}, {1'b0, 1'b1, (i == 9), 8'(i)});
      end
      cyc();
    end
    bus.sym_in_tdata = 8'hEE; bus.sym_in_tlast = 1'b0; bus.lut_in_tready = 1'b0;
    @(negedge aclk);
    n_tests++;
    if (bus.sym_in_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL passthrough_backpressure got %b required 0", bus.sym_in_tready);
    end
    cyc();
    bus.sym_in_tvalid = 1'b0; bus.lut_in_tready = 1'b1;
    cyc();
  endtask

  task automatic test_frame_align_drain();
    int k;
    for (int i = 0; i < 8; i++) begin
      bus.sym_in_tdata = 8'(20 + i); bus.sym_in_tlast = (i == 7); bus.sym_in_tvalid = 1'b1;
      bus.reload_req = (i == 3);
      if (i == 7) out_rdy = 1'b0;
      in_q.push_back({(i == 7), 8'(20 + i)});
      @(negedge aclk);
      n_tests++;
      if (bus.reload_busy !== (i >= 4)) begin
        n_fail++;
        $display("FAIL frame_busy beat %0d got %b required %b", i, bus.reload_busy, (i >= 4));
      end
      cyc();
    end
    bus.reload_req = 1'b0; bus.sym_in_tdata = 8'h99; bus.sym_in_tlast = 1'b0;
    bus.lut_load_tready = 1'b1; bus.cfg_in_tvalid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge aclk);
      n_tests++;
      if ({bus.sym_in_tready, bus.lut_in_tvalid, bus.cfg_in_tready, bus.reload_busy} !== 4'b0001) begin
        n_fail++;
        $display("FAIL drain_hold cycle %0d got %b required 0001", j,
                 {bus.sym_in_tready, bus.lut_in_tvalid, bus.cfg_in_tready, bus.reload_busy});
      end
      cyc();
    end
    out_rdy = 1'b1;
    k = 0;
    while (bus.cfg_in_tready !== 1'b1 && k < 20) begin
      cyc();
      k++;
    end
    n_tests++;
    if (k != 3) begin
      n_fail++;
      $display("FAIL drain_to_load got %0d cycles required 3", k);
    end
    bus.sym_in_tvalid = 1'b0;
  endtask

  task automatic test_full_load();
    for (int i = 0; i < DEPTH; i++) begin
      if (i % 50 == 17) begin
        bus.cfg_in_tvalid = 1'b0;
        @(negedge aclk);
        n_tests++;
        if (bus.lut_load_tvalid !== 1'b0) begin
          n_fail++;
          $display("FAIL load_gap got %b required 0", bus.lut_load_tvalid);
        end
        cyc();
      end
      bus.cfg_in_tdata = 32'hC0DE_0000 + 32'(i); bus.cfg_in_tlast = (i == DEPTH - 1); bus.cfg_in_tvalid = 1'b1;
      load_q.push_back({(i == DEPTH - 1), 32'hC0DE_0000 + 32'(i)});
      if (i == 100) begin
        bus.lut_load_tready = 1'b0;
        @(negedge aclk);
        n_tests++;
        if (bus.cfg_in_tready !== 1'b0) begin
          n_fail++;
          $display("FAIL load_backpressure got %b required 0", bus.cfg_in_tready);
        end
        cyc();
        bus.lut_load_tready = 1'b1;
      end
      cyc();
    end
    bus.cfg_in_tvalid = 1'b0; bus.cfg_in_tlast = 1'b0;
    bus.sym_in_tvalid = 1'b1; bus.sym_in_tdata = 8'h77;
    @(negedge aclk);
    n_tests++;
    if ({bus.reload_done, bus.load_error, bus.reload_busy, bus.sym_in_tready} !== 4'b1010) begin
      n_fail++;
      $display("FAIL full_done got %b required 1010",
               {bus.reload_done, bus.load_error, bus.reload_busy, bus.sym_in_tready});
    end
    bus.sym_in_tvalid = 1'b0;
    cyc();
    @(negedge aclk);
    n_tests++;
    if ({bus.reload_done, bus.reload_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL full_resume got %b required 00", {bus.reload_done, bus.reload_busy});
    end
  endtask

  task automatic test_early_tlast();
    for (int i = 0; i < 2; i++) begin
      bus.sym_in_tdata = 8'(40 + i); bus.sym_in_tlast = (i == 1); bus.sym_in_tvalid = 1'b1;
      bus.reload_req = (i == 0);
      in_q.push_back({(i == 1), 8'(40 + i)});
      cyc();
    end
    bus.reload_req = 1'b0; bus.sym_in_tvalid = 1'b0; bus.sym_in_tlast = 1'b0;
    wait_load("early");
    for (int i = 0; i < 100; i++) begin
      bus.cfg_in_tdata = 32'h0BAD_0000 + 32'(i); bus.cfg_in_tlast = (i == 99); bus.cfg_in_tvalid = 1'b1;
      load_q.push_back({(i == 99), 32'h0BAD_0000 + 32'(i)});
      cyc();
    end
    bus.cfg_in_tvalid = 1'b0; bus.cfg_in_tlast = 1'b0;
    @(negedge aclk);
    n_tests++;
    if ({bus.reload_done, bus.load_error} !== 2'b11) begin
      n_fail++;
      $display("FAIL early_done got %b required 11", {bus.reload_done, bus.load_error});
    end
    cyc();
    bus.sym_in_tdata = 8'h07; bus.sym_in_tvalid = 1'b1;
    in_q.push_back({1'b0, 8'h07});
    @(negedge aclk);
    n_tests++;
    if ({bus.reload_busy, bus.load_error, bus.lut_in_tvalid} !== 3'b011) begin
      n_fail++;
      $display("FAIL early_resume got %b required 011", {bus.reload_busy, bus.load_error, bus.lut_in_tvalid});
    end
    cyc();
    bus.sym_in_tvalid = 1'b0;
    bus.reload_req = 1'b1;
    cyc();
    bus.reload_req = 1'b0;
    @(negedge aclk);
    n_tests++;
    if ({bus.load_error, bus.reload_busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL error_clear got %b required 01", {bus.load_error, bus.reload_busy});
    end
  endtask

  task automatic test_reset_mid_load();
    cyc();
    bus.sym_in_tdata = 8'd50; bus.sym_in_tlast = 1'b1; bus.sym_in_tvalid = 1'b1;
    in_q.push_back({1'b1, 8'd50});
    cyc();
    bus.sym_in_tvalid = 1'b0; bus.sym_in_tlast = 1'b0;
    wait_load("midreset");
    for (int i = 0; i < 40; i++) begin
      bus.cfg_in_tdata = 32'h1234_0000 + 32'(i); bus.cfg_in_tlast = 1'b0; bus.cfg_in_tvalid = 1'b1;
      load_q.push_back({1'b0, 32'h1234_0000 + 32'(i)});
      cyc();
    end
    bus.cfg_in_tdata = 32'h1234_0028; bus.sym_in_tvalid = 1'b1; bus.sym_in_tdata = 8'h11;
    #1 aresetn = 1'b0;
    #1;
    n_tests++;
    if ({bus.lut_load_tvalid, bus.lut_load_tlast, bus.cfg_in_tready, bus.lut_in_tvalid, bus.sym_in_tready,
         bus.reload_busy, bus.reload_done, bus.load_error} !== 8'b0) begin
      n_fail++;
      $display("FAIL midload_reset got %b required 00000000",
               {bus.lut_load_tvalid, bus.lut_load_tlast, bus.cfg_in_tready, bus.lut_in_tvalid, bus.sym_in_tready,
                bus.reload_busy, bus.reload_done, bus.load_error});
    end
    bus.cfg_in_tvalid = 1'b0; bus.sym_in_tvalid = 1'b0;
    cyc(); cyc();
    aresetn = 1'b1;
    cyc();
    bus.sym_in_tdata = 8'h03; bus.sym_in_tvalid = 1'b1;
    in_q.push_back({1'b0, 8'h03});
    @(negedge aclk);
    n_tests++;
    if ({bus.reload_busy, bus.lut_in_tvalid} !== 2'b01) begin
      n_fail++;
      $display("FAIL midload_resume got %b required 01", {bus.reload_busy, bus.lut_in_tvalid});
    end
    cyc();
    bus.sym_in_tvalid = 1'b0;
    cyc(); cyc();
  endtask

  initial begin
    bus.sym_in_tdata = '0; bus.sym_in_tvalid = 1'b0; bus.sym_in_tlast = 1'b0;
    bus.cfg_in_tdata = '0; bus.cfg_in_tvalid = 1'b0; bus.cfg_in_tlast = 1'b0;
    bus.lut_in_tready = 1'b0; bus.lut_load_tready = 1'b0; bus.reload_req = 1'b0;
    #1;
    test_reset();
    test_passthrough();
    test_frame_align_drain();
    test_full_load();
    test_early_tlast();
    test_reset_mid_load();
    n_tests++;
    if (in_q.size() != 0 || load_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d/%0d pending required 0/0", in_q.size(), load_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
